// File: rtl/jesd204b_tx_link_ctrl.sv
// JESD204B transmit link-layer sequencer: CGS -> 4-multiframe ILAS -> user data,
// driven by the LMFC pulse and the receiver's SYNC~ request.
module jesd204b_tx_link_ctrl #(
    parameter int SYNC_LEN = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_K,
    input  logic       i_lmfc_clk,
    input  logic       i_sync_n,
    output logic       o_cgs,
    output logic       o_ilas,
    output logic [1:0] o_ilas_mf,
    output logic       o_ilas_r,
    output logic       o_ilas_q,
    output logic       o_ilas_a,
    output logic       o_data_en,
    output logic       o_sync_err
);

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [5:0] LOW_LAST = 6'(SYNC_LEN - 1);

    state_t     state_reg, state_next;
    logic [1:0] mf_reg, mf_next;
    logic [5:0] ph_reg, ph_next;
    logic [5:0] low_reg, low_next;
    logic       sync_meta_reg, sync_s_reg;
    logic       entering, err_next, ilas_next;

    // Phase within the multiframe; saturates so a missing LMFC cannot wrap it.
    always_comb begin
        if (i_lmfc_clk)
            ph_next = 6'd0;
        else if (ph_reg == 6'd63)
            ph_next = 6'd63;
        else
            ph_next = ph_reg + 6'd1;
    end

    always_comb begin
        state_next = state_reg;
        mf_next    = mf_reg;
        low_next   = low_reg;
        entering   = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            CGS: begin
                low_next = 6'd0;
                if (sync_s_reg && i_lmfc_clk) begin
                    state_next = ILAS;
                    mf_next    = 2'd0;
                    entering   = 1'b1;
                end
            end
            default: begin
                if (!sync_s_reg) begin
                    if (low_reg == LOW_LAST) begin
                        state_next = CGS;
                        mf_next    = 2'd0;
                        low_next   = 6'd0;
                    end else begin
                        low_next = low_reg + 6'd1;
                    end
                end else begin
                    low_next = 6'd0;
                    err_next = (low_reg != 6'd0);
                end
                // Loss of sync wins over a coincident LMFC pulse.
                if (state_next != CGS && state_reg == ILAS && i_lmfc_clk) begin
                    if (mf_reg == 2'd3)
                        state_next = DATA;
                    else
                        mf_next = mf_reg + 2'd1;
                end
            end
        endcase
    end

    assign ilas_next = (state_next == ILAS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_reg <= 1'b0;
            sync_s_reg    <= 1'b0;
            state_reg     <= CGS;
            mf_reg        <= 2'd0;
            ph_reg        <= 6'd0;
            low_reg       <= 6'd0;
            o_cgs         <= 1'b1;
            o_ilas        <= 1'b0;
            o_ilas_mf     <= 2'd0;
            o_ilas_r      <= 1'b0;
            o_ilas_q      <= 1'b0;
            o_ilas_a      <= 1'b0;
            o_data_en     <= 1'b0;
            o_sync_err    <= 1'b0;
        end else begin
            sync_meta_reg <= i_sync_n;
            sync_s_reg    <= sync_meta_reg;
            state_reg     <= state_next;
            mf_reg        <= mf_next;
            ph_reg        <= ph_next;
            low_reg       <= low_next;
            o_cgs         <= (state_next == CGS);
            o_ilas        <= ilas_next;
            o_data_en     <= (state_next == DATA);
            o_ilas_mf     <= ilas_next ? mf_next : 2'd0;
            o_ilas_r      <= ilas_next && (ph_next == 6'd0) && (entering || i_lmfc_clk);
            o_ilas_q      <= ilas_next && (mf_next == 2'd1) && (ph_next == 6'd1) && (i_K != 5'd0);
            o_ilas_a      <= ilas_next && (ph_next == {1'b0, i_K});
            o_sync_err    <= err_next;
        end
    end

endmodule

// File: doc/jesd204b_tx_link_ctrl.md
# jesd204b_tx_link_ctrl

Transmit-side JESD204B link-layer sequencer that sits directly downstream of the frame/LMFC clock generator. It consumes the one-cycle LMFC pulse and the receiver's SYNC~ request, and steps the lane through Code Group Synchronization (CGS), the 4-multiframe Initial Lane Alignment Sequence (ILAS), and user data. It emits per-cycle control strobes that tell the downstream character mux what to send: /K/, /R/, /Q/, /A/ or payload.

## Interface
- SYNC_LEN, 5: number of consecutive device-clock cycles of synchronized SYNC~ low, while in ILAS or DATA, that forces re-synchronization. Legal range is 2..63.
- clk  input  1  device clock.
- rst  input  1  asynchronous, active-high reset.
- i_K  input  5  frames per multiframe minus 1 (1..32). Static outside CGS.
- i_lmfc_clk  input  1  one-cycle pulse, period i_K+1 cycles. The cycle after the pulse is the first cycle of a multiframe.
- i_sync_n  input  1  SYNC~ from the receiver, active low, asynchronous to clk.
- o_cgs  output  1  send /K/ characters.
- o_ilas  output  1  ILAS in progress.
- o_ilas_mf  output  2  index of the current ILAS multiframe, 0..3.
- o_ilas_r  output  1  first cycle of an ILAS multiframe (/R/).
- o_ilas_q  output  1  second cycle of ILAS multiframe 1 (/Q/, configuration data follows).
- o_ilas_a  output  1  last cycle of an ILAS multiframe (/A/).
- o_data_en  output  1  user data lane enabled.
- o_sync_err  output  1  one-cycle pulse marking a SYNC~ error report (short low pulse).

## Operation
- **SYNC~ synchronizer:** 2-flop synchronizer produces sync_s. Both flops reset to 0, so after reset the request is treated as asserted.
- **Phase counter ph (6 bits):**
  - ph <= i_lmfc_clk ? 0 : ph+1, saturating at 63.
  - nph denotes the next value of ph.
- **State machine:** states CGS=0, ILAS=1, DATA=2. Reset state is CGS.
- **CGS → ILAS:** on a cycle with sync_s==1 and i_lmfc_clk==1. ilas_mf <= 0.
  - sync_s high without an LMFC pulse keeps the block in CGS.
- **ILAS:** each i_lmfc_clk pulse increments ilas_mf. A pulse seen while ilas_mf==3 moves to DATA.
- **Loss of sync (ILAS or DATA):**
  - lowcnt (6 bits) counts consecutive sync_s==0 cycles and clears when sync_s==1.
  - When lowcnt reaches SYNC_LEN-1 while sync_s==0 (i.e. the SYNC_LEN-th low cycle), go to CGS on that edge.
  - If sync_s rises after 1..SYNC_LEN-1 low cycles, pulse o_sync_err for one cycle and stay in the current state.
  - In CGS, sync_s low is normal: lowcnt is held at 0 and no error is raised.
- **Registered outputs:** all outputs are registered and decoded from next-state values.
  - o_cgs = (state==CGS); o_ilas = (state==ILAS); o_data_en = (state==DATA).
  - o_ilas_mf mirrors ilas_mf in ILAS and is 0 otherwise.
  - o_ilas_r <= next_state==ILAS && nph==0 && (entering ILAS or i_lmfc_clk).
  - o_ilas_q <= next_state==ILAS && next ilas_mf==1 && nph==1. It never asserts when i_K==0 (only one cycle per multiframe).
  - o_ilas_a <= next_state==ILAS && nph==i_K.
  - When i_K==0, o_ilas_r and o_ilas_a are high together.
- **Width rules:**
  - ph is compared against zero-extended {1'b0,i_K}.
  - ilas_mf is 2 bits and never wraps, because the exit happens at index 3.
- **Asynchronous reset mid-operation:** returns to CGS immediately with all counters at 0.

## Timing
- **Reset values:**
  - o_cgs=1.
  - o_ilas, o_ilas_r, o_ilas_q, o_ilas_a, o_data_en, o_sync_err = 0.
  - o_ilas_mf = 0.
- **SYNC~ latency:** an i_sync_n edge sampled at edge S is visible as sync_s after edge S+1.
- **ILAS entry and length:**
  - LMFC pulse at cycle T with sync_s==1 in CGS gives o_ilas=1, o_cgs=0, o_ilas_r=1, o_ilas_mf=0 at cycle T+1.
  - ILAS lasts exactly 4(i_K+1) cycles: T+1 .. T+4(i_K+1).
- **DATA entry:** o_data_en=1 from cycle T+4(i_K+1)+1.
- **Loss-of-sync exit:** exactly SYNC_LEN cycles after sync_s first reads 0, o_cgs=1 and all ILAS/data outputs are 0.
- **Simultaneous events:**
  - An LMFC pulse coinciding with loss-of-sync (lowcnt reaching SYNC_LEN-1) resolves to CGS; loss-of-sync has priority.
  - sync_s rising in CGS on the same cycle as an LMFC pulse enters ILAS.

## Test plan
- Reset with i_K=3 and i_sync_n=0 → o_cgs=1 and every other output 0, held indefinitely while pulses arrive every 4 cycles.
- Release i_sync_n, then LMFC pulse at T → o_ilas_r at T+1, T+5, T+9, T+13; o_ilas_a at T+4, T+8, T+12, T+16; o_ilas_q only at T+6; o_data_en=1 from T+17.
- i_K=0 → ILAS lasts 4 cycles, with o_ilas_r and o_ilas_a both high every ILAS cycle and o_ilas_q never asserted.
- In DATA, drive a 3-cycle i_sync_n low pulse (SYNC_LEN=5) → one o_sync_err pulse, o_data_en stays 1.
- In DATA, drive i_sync_n low for 10 cycles → o_cgs=1 exactly 5 cycles after sync_s falls, no o_sync_err; then release → ILAS re-entry on the next LMFC pulse.
- Assert rst mid-ILAS (o_ilas_mf=2) → outputs return to reset values immediately; after release, ILAS restarts only with the synchronizer re-filled and a fresh LMFC pulse.
